mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 tb/tb_mult_div_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiply, restoring divide.
// Latency 33 cycles start-to-done; start while busy is dropped, MTHI/MTLO honoured only when idle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_sgn;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_sub;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_accept;
    logic               w_mt_ok;

    assign w_sgn    = ~op[0];
    assign w_is_div = op[1];
    assign w_abs_a  = (w_sgn && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (w_sgn && b[WIDTH-1]) ? -b : b;
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_mt_ok  = (r_state == S_IDLE) && !start;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    // Divide: acc = {remainder, dividend/quotient bits}, shifted left each step.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_sub   = w_shift - {1'b0, r_opnd};
    assign w_ge    = w_shift >= {1'b0, r_opnd};

    always_comb begin
        w_step = r_acc;
        if (r_is_div) begin
            if (w_ge)
                w_step = {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
                w_step = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else if (r_acc[0]) begin
            w_step = {w_sum, r_acc[WIDTH-1:1]};
        end else begin
            w_step = {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_RUN;
                        r_cnt    <= CW'(WIDTH - 1);
                        r_is_div <= w_is_div;
                        r_acc    <= {{WIDTH{1'b0}}, w_is_div ? w_abs_a : w_abs_b};
                        r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                        // A zero divisor leaves the all-ones quotient unsigned.
                        r_neg_q  <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && (!w_is_div || (|b));
                        r_neg_r  <= w_sgn && w_is_div && a[WIDTH-1];
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_mt_ok && mthi)
                r_hi <= wdata;
            if (w_mt_ok && mtlo)
                r_lo <= wdata;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops vs. an arithmetic model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {HI, LO} as the MIPS instruction set defines them.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: p = 64'(sx * sy);
            2'd1: p = {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else if (o == 2'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {x % y, x / y};
                end
            end
        endcase
        return p;
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    // inj: 0 none, 1 start+mthi pulse while busy, 2 mthi together with start.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int inj);
        logic [63:0] exp;
        bit          ok;
        exp   = model(o, x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (inj == 2) begin
            mthi  = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        ok    = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo)
                ok = 1'b0;
            if (inj == 1 && k == 4) begin
                start = 1'b1;
                op    = 2'($urandom);
                mthi  = 1'b1;
                wdata = 32'h0000_1234;
            end
            if (k == 5) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, " busy/hold"}, {31'd0, ok}, 32'd1);
        check({tag, " done"}, {30'd0, busy, done}, 32'd1);
        check({tag, " hi"}, hi, exp[63:32]);
        check({tag, " lo"}, lo, exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          ok;

        reset = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = '0;
        #1;
        check("reset state", {busy, done, 30'd0}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 0);
        @(negedge clk);
        check("done one cycle", {31'd0, done}, 32'd0);
        run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        run_op("mult -1*-1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        @(negedge clk);
        run_op("divu by 0", 2'd3, 32'd100, 32'd0, 0);
        @(negedge clk);
        run_op("div neg by 0", 2'd2, 32'hFFFF_FF9C, 32'd0, 0);
        @(negedge clk);
        run_op("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        run_op("divu ignore", 2'd3, 32'hFFFF_0000, 32'd7, 1);
        @(negedge clk);
        run_op("mthi with start", 2'd1, 32'd12345, 32'd678, 2);
        @(negedge clk);

        // Abort a MULT with an asynchronous mid-cycle reset.
        start = 1'b1;
        op    = 2'd0;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 9; k++) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort busy/done", {30'd0, busy, done}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
                ok = 1'b0;
        end
        check("post-abort quiet", {31'd0, ok}, 32'd1);

        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        mthi  = 1'b0;
        mtlo  = 1'b0;
        m_hi  = 32'hCAFE_F00D;
        m_lo  = 32'hCAFE_F00D;
        check("mthi+mtlo hi", hi, m_hi);
        check("mthi+mtlo lo", lo, m_lo);
        mtlo  = 1'b1;
        wdata = 32'h0BAD_F00D;
        @(negedge clk);
        mtlo  = 1'b0;
        m_lo  = 32'h0BAD_F00D;
        check("mtlo only hi", hi, m_hi);
        check("mtlo only lo", lo, m_lo);

        run_op("b2b first", 2'd2, 32'd1000, 32'hFFFF_FFFD, 0);
        run_op("b2b second", 2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", n, ro), ro, ra, rb, 0);
            if ($urandom_range(0, 1) == 1)
                @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
